// File: rtl/sram_1rw_req_ctrl_pkg.sv
// Shared types and default sizes for the 1RW SRAM requester controller.
package sram_ctrl_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 334;

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {READ, WRITE} grant_t;

endpackage

// File: rtl/sram_1rw_req_ctrl_if.sv
// Request/response channels plus the SRAM macro port, grouped for the controller.
interface sram_1rw_req_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  logic              r_req_valid;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_req_addr;

  logic              r_resp_valid;
  logic              r_resp_ready;
  logic [DATA_W-1:0] r_resp_data;

  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  // slave is the controller's view; master is the requester plus macro side
  modport slave (
    input  w_valid, w_addr, w_data,
    output w_ready,
    input  r_req_valid, r_req_addr,
    output r_req_ready,
    output r_resp_valid, r_resp_data,
    input  r_resp_ready,
    output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output w_valid, w_addr, w_data,
    input  w_ready,
    output r_req_valid, r_req_addr,
    input  r_req_ready,
    input  r_resp_valid, r_resp_data,
    output r_resp_ready,
    input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/sram_resp_fifo2.sv
// Two-entry in-order response buffer; head_data is valid whenever count != 0.
module sram_resp_fifo2 #(
  parameter int DATA_W = 334
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // storage is left unreset; only the pointers and occupancy matter
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Zero-fills a 1RW SRAM after reset, then arbitrates write and read requests
// onto the single port and buffers read data in order.
module sram_1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 init_done,
  sram_1rw_req_ctrl_if.slave   bus
);

  state_t            state;
  grant_t            last_grant;
  grant_t            winner;
  logic [ADDR_W-1:0] init_idx;
  logic              rd_inflight;
  logic [1:0]        buf_count;
  logic              active;
  logic              can_rd;
  logic              r_elig;
  logic              grant_w;
  logic              grant_r;
  logic              pop;

  assign active = (state == RUN) && !reset;
  // a slot is reserved for the read already on the port
  assign can_rd = ({1'b0, buf_count} + {2'b00, rd_inflight}) < 3'd2;
  assign r_elig = bus.r_req_valid && can_rd;

  always_comb begin
    winner = READ;
    if (bus.w_valid && r_elig) begin
      winner = (last_grant == READ) ? WRITE : READ;
    end else if (bus.w_valid) begin
      winner = WRITE;
    end
    grant_w         = active && bus.w_valid && (winner == WRITE);
    grant_r         = active && r_elig && (winner == READ);
    bus.w_ready     = active && ((winner == WRITE) || !bus.r_req_valid || !can_rd);
    bus.r_req_ready = active && can_rd && (winner == READ);
  end

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (state == INIT && !reset) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = init_idx;
    end else if (grant_w) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = bus.w_addr;
      bus.sram_wdata = bus.w_data;
    end else if (grant_r) begin
      bus.sram_en    = 1'b1;
      bus.sram_addr  = bus.r_req_addr;
    end
    bus.sram_wmask = bus.sram_en && bus.sram_wmode;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= INIT;
      init_idx    <= '0;
      init_done   <= 1'b0;
      last_grant  <= READ;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= grant_r;
      case (state)
        INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (grant_w) begin
            last_grant <= WRITE;
          end else if (grant_r) begin
            last_grant <= READ;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign pop              = bus.r_resp_valid && bus.r_resp_ready;
  assign bus.r_resp_valid = (buf_count != 2'd0);

  // macro rdata only holds until the next access, so it is captured unconditionally
  sram_resp_fifo2 #(.DATA_W(DATA_W)) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_inflight),
    .push_data (bus.sram_rdata),
    .pop       (pop),
    .head_data (bus.r_resp_data),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Directed bench for sram_1rw_req_ctrl: behavioural 1RW macro, reference memory
// and an in-order scoreboard of expected read responses.
module tb_sram_1rw_req_ctrl;
  import sram_ctrl_pkg::*;

  localparam int DEPTH  = DEF_DEPTH;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int DATA_W = DEF_DATA_W;

  logic clock = 1'b0;
  logic reset;
  logic init_done;

  int checks     = 0;
  int errors     = 0;
  int resp_count = 0;
  int rc0;
  int n_acc;

  logic [DATA_W-1:0] ref_mem  [DEPTH];
  logic [DATA_W-1:0] sram_mem [DEPTH];
  logic [DATA_W-1:0] exp_q    [$];
  logic [DATA_W-1:0] pat_5a, val_a, val_b, val_c, val_d;

  sram_1rw_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_1rw_req_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .init_done (init_done),
    .bus       (bus.slave)
  );

  always #5 clock = ~clock;

  // macro model: registered read data that holds until the next read
  always @(posedge clock) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) sram_mem[bus.sram_addr] <= bus.sram_wdata;
      else                bus.sram_rdata <= sram_mem[bus.sram_addr];
    end
  end

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  task automatic check_word(input string tag, input logic [DATA_W-1:0] observed,
                            input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic w_v, input int w_a, input logic [DATA_W-1:0] w_d,
                                input logic r_v, input int r_a);
    bus.w_valid     = w_v;
    bus.w_addr      = ADDR_W'(w_a);
    bus.w_data      = w_d;
    bus.r_req_valid = r_v;
    bus.r_req_addr  = ADDR_W'(r_a);
  endtask

  // handshakes seen at the negedge drive the reference memory and scoreboard
  task automatic check_output();
    logic [DATA_W-1:0] exp_d;
    if (!reset) begin
      if (bus.r_resp_valid && bus.r_resp_ready) begin
        resp_count++;
        check_bit("resp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          check_word("resp_data", bus.r_resp_data, exp_d);
        end
      end
      if (bus.w_valid && bus.w_ready) ref_mem[bus.w_addr] = bus.w_data;
      if (bus.r_req_valid && bus.r_req_ready) exp_q.push_back(ref_mem[bus.r_req_addr]);
    end
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic advance();
    check_output();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic check_init();
    for (int i = 0; i < DEPTH; i++) begin
      sample();
      check_bit("init_en", bus.sram_en, 1'b1);
      check_bit("init_wmode", bus.sram_wmode, 1'b1);
      check_bit("init_wmask", bus.sram_wmask, 1'b1);
      check_word("init_addr", DATA_W'(bus.sram_addr), DATA_W'(i));
      check_word("init_wdata", bus.sram_wdata, '0);
      check_bit("init_w_ready", bus.w_ready, 1'b0);
      check_bit("init_r_req_ready", bus.r_req_ready, 1'b0);
      check_bit("init_done_low", init_done, 1'b0);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_init_done"}, init_done, 1'b0);
    check_bit({tag, "_w_ready"}, bus.w_ready, 1'b0);
    check_bit({tag, "_r_req_ready"}, bus.r_req_ready, 1'b0);
    check_bit({tag, "_r_resp_valid"}, bus.r_resp_valid, 1'b0);
    check_bit({tag, "_sram_en"}, bus.sram_en, 1'b0);
    check_bit({tag, "_sram_wmode"}, bus.sram_wmode, 1'b0);
  endtask

  initial begin
    pat_5a = DATA_W'({42{8'h5A}});
    val_a  = DATA_W'({11{$urandom()}});
    val_b  = DATA_W'({11{$urandom()}});
    val_c  = DATA_W'({11{$urandom()}});
    val_d  = DATA_W'({11{$urandom()}});
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]  = '0;
      sram_mem[i] = DATA_W'({11{$urandom()}});
    end
    reset            = 1'b1;
    bus.r_resp_ready = 1'b1;
    apply_stimulus(0, 0, '0, 0, 0);

    // reset values, then zero-fill with requests already pending
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    sample();
    check_reset_outputs("rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    apply_stimulus(1, 1, val_a, 1, 2);
    check_init();
    apply_stimulus(0, 0, '0, 0, 0);
    sample();
    check_bit("init_done_high", init_done, 1'b1);
    check_bit("run_idle_en", bus.sram_en, 1'b0);
    check_bit("run_idle_w_ready", bus.w_ready, 1'b1);
    check_bit("run_idle_r_req_ready", bus.r_req_ready, 1'b1);
    advance();

    // zeroed contents after init
    rc0 = resp_count;
    apply_stimulus(0, 0, '0, 1, 0);
    cycle();
    apply_stimulus(0, 0, '0, 1, 3);
    cycle();
    apply_stimulus(0, 0, '0, 0, 0);
    repeat (3) cycle();
    check_word("zero_reads", DATA_W'(resp_count - rc0), DATA_W'(2));

    // write then read-after-write, with response latency
    apply_stimulus(1, 2, pat_5a, 0, 0);
    sample();
    check_bit("wr_en", bus.sram_en, 1'b1);
    check_bit("wr_wmode", bus.sram_wmode, 1'b1);
    check_word("wr_addr", DATA_W'(bus.sram_addr), DATA_W'(2));
    check_word("wr_wdata", bus.sram_wdata, pat_5a);
    advance();
    apply_stimulus(0, 0, '0, 1, 2);
    sample();
    check_bit("raw_r_req_ready", bus.r_req_ready, 1'b1);
    check_bit("raw_wmode", bus.sram_wmode, 1'b0);
    advance();
    apply_stimulus(0, 0, '0, 0, 0);
    sample();
    check_bit("lat_cycle1", bus.r_resp_valid, 1'b0);
    advance();
    sample();
    check_bit("lat_cycle2", bus.r_resp_valid, 1'b1);
    check_word("raw_data", bus.r_resp_data, pat_5a);
    advance();

    // alternation starting after a write grant
    apply_stimulus(1, 0, val_c, 0, 0);
    cycle();
    rc0 = resp_count;
    apply_stimulus(1, 3, val_d, 1, 2);
    for (int i = 0; i < 6; i++) begin
      sample();
      check_bit("alt_en", bus.sram_en, 1'b1);
      check_bit($sformatf("alt_wmode_%0d", i), bus.sram_wmode, (i % 2) == 1);
      advance();
    end
    apply_stimulus(0, 0, '0, 0, 0);
    repeat (3) cycle();
    check_word("alt_resp_count", DATA_W'(resp_count - rc0), DATA_W'(3));

    // back-pressure: four reads offered, two fit
    apply_stimulus(1, 1, val_a, 0, 0);
    cycle();
    bus.r_resp_ready = 1'b0;
    rc0   = resp_count;
    n_acc = 0;
    apply_stimulus(0, 0, '0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      sample();
      check_bit($sformatf("bp_r_req_ready_%0d", i), bus.r_req_ready, i < 2);
      if (bus.r_req_ready) n_acc++;
      advance();
      bus.r_req_addr = ADDR_W'(n_acc);
    end
    check_word("bp_accepted", DATA_W'(n_acc), DATA_W'(2));
    apply_stimulus(0, 0, '0, 0, 0);
    sample();
    check_bit("bp_valid", bus.r_resp_valid, 1'b1);
    check_word("bp_head", bus.r_resp_data, val_c);
    advance();
    sample();
    check_word("bp_head_hold", bus.r_resp_data, val_c);
    check_bit("bp_full_ready", bus.r_req_ready, 1'b0);
    advance();
    bus.r_resp_ready = 1'b1;
    repeat (3) cycle();
    check_word("bp_drained", DATA_W'(resp_count - rc0), DATA_W'(2));

    // write to the same address in the capture cycle returns the old value
    apply_stimulus(0, 0, '0, 1, 1);
    cycle();
    apply_stimulus(1, 1, val_b, 0, 0);
    sample();
    check_bit("cap_w_ready", bus.w_ready, 1'b1);
    check_bit("cap_wmode", bus.sram_wmode, 1'b1);
    advance();
    apply_stimulus(0, 0, '0, 0, 0);
    repeat (2) cycle();
    apply_stimulus(0, 0, '0, 1, 1);
    cycle();
    apply_stimulus(0, 0, '0, 0, 0);
    repeat (3) cycle();
    check_word("cap_queue_empty", DATA_W'(exp_q.size()), '0);

    // reset with one read in flight and one response buffered
    bus.r_resp_ready = 1'b0;
    apply_stimulus(0, 0, '0, 1, 2);
    cycle();
    apply_stimulus(0, 0, '0, 1, 3);
    cycle();
    apply_stimulus(0, 0, '0, 0, 0);
    reset = 1'b1;
    exp_q.delete();
    sample();
    @(posedge clock);
    #1;
    sample();
    check_reset_outputs("mid_rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    check_init();
    bus.r_resp_ready = 1'b1;
    rc0 = resp_count;
    sample();
    check_bit("rerun_init_done", init_done, 1'b1);
    advance();
    repeat (3) cycle();
    check_word("no_stale_resp", DATA_W'(resp_count - rc0), '0);
    apply_stimulus(0, 0, '0, 1, 3);
    cycle();
    apply_stimulus(0, 0, '0, 0, 0);
    repeat (3) cycle();
    check_word("post_rst_read", DATA_W'(resp_count - rc0), DATA_W'(1));
    check_word("final_queue_empty", DATA_W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
